axis_image_pattern_vip: RTL and testbench
=========================================

Name: axis_image_pattern_vip

Overview:
Parametrised AXI4-Stream image verification IP, replacing file-driven stimulus with on-chip generation.
- Source side emits NUM_FRAMES frames of IMG_W x IMG_H pixels in a selectable pattern, with tuser at start of frame (SOF) and tlast at end of line (EOL).
- Sink side accepts a stream, checks SOF/EOL framing against the same geometry, accumulates a per-frame checksum and counts errors.
- Both sides support pseudo-random valid/ready throttling and a stall timeout.
- Sits in block-level benches, or on FPGA for board bring-up, between DUT ports.

Parameters:
PIX_BYTES, 3, bytes per pixel; data width DW = PIX_BYTES*8
IMG_W, 64, pixels per line (>=2)
IMG_H, 48, lines per frame (>=1)
NUM_FRAMES, 2, frames sourced, and frames expected at sink, before done
THROTTLE, 0, 0..15; a side idles on cycles where its LFSR[3:0] < THROTTLE (0 = no throttling)
TIMEOUT_CYCLE, 1000, consecutive no-handshake cycles before timeout

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
start_i  in  1  pulse; starts or restarts a run
pattern_sel_i  in  2  0 ramp, 1 constant, 2 PRBS, 3 checkerboard
fill_i  in  DW  constant-pattern value
axis_m_data_o  out  DW  source pixel
axis_m_valid_o  out  1  source valid
axis_m_ready_i  in  1  downstream ready
axis_m_last_o  out  1  EOL
axis_m_user_o  out  1  SOF
axis_s_data_i  in  DW  sink pixel
axis_s_valid_i  in  1  upstream valid
axis_s_ready_o  out  1  sink ready
axis_s_last_i  in  1  EOL
axis_s_user_i  in  1  SOF
done_o  out  1  sticky; source finished AND sink received NUM_FRAMES frames
timeout_o  out  1  sticky; stall timeout hit
err_cnt_o  out  16  saturating framing-error count
frame_cnt_o  out  16  frames completed at sink
checksum_o  out  32  sum mod 2^32 of DW-zero-extended sink data, last completed frame

Behaviour:
- Reset values: all outputs 0, both LFSRs loaded with seed 32'hACE1_0001 (source) and 32'h1357_9BDF (sink), source FSM = IDLE.
- Handshake: beat transfers when valid && ready at posedge.
- Source FSM:
  - IDLE: start_i -> STREAM.
  - STREAM: -> DONE after the beat with x=IMG_W-1, y=IMG_H-1, f=NUM_FRAMES-1 transfers, or when timeout_o sets.
  - DONE: start_i -> STREAM.
  - Entering STREAM clears x, y, f, the sink counters and the sticky flags.
- Source counters x/y/f advance only on a transfer, with x wrapping to y, y wrapping to f.
- axis_m_last_o = (x==IMG_W-1); axis_m_user_o = (x==0 && y==0); both are combinational from registered counters.
- Valid rules in STREAM:
  - When valid is 0, valid rises on the next cycle with LFSR[3:0] >= THROTTLE.
  - Once asserted, valid, data, last and user stay stable until transfer (AXI rule). Throttle never drops valid.
- Source LFSR steps every cycle.
- Patterns:
  - ramp: data = (y*IMG_W + x) truncated to DW.
  - constant: fill_i, sampled at start.
  - PRBS: separate 32-bit Galois LFSR (poly 32'h8020_0003), steps per transfer; data = low DW bits, zero-extended if DW>32.
  - checkerboard: all-ones if x[0]^y[0], else 0.
- pattern_sel_i is sampled at start_i; later changes are ignored until the next start.
- Sink:
  - axis_s_ready_o = rstn_i && (sink LFSR[3:0] >= THROTTLE); ready may drop between beats.
  - Sink keeps its own sx/sy counters.
  - Per transfer, each mismatch increments err_cnt_o (saturating at 16'hFFFF): last != (sx==IMG_W-1); user != (sx==0 && sy==0). A beat with both mismatches adds 2.
  - A transfer with user=1 while sx!=0 or sy!=0 resyncs: sx=1, sy=0, and the checksum restarts from this beat.
  - At frame end (sx=IMG_W-1, sy=IMG_H-1, transfer): checksum_o <= acc + data, frame_cnt_o increments, acc clears.
  - Sink beats outside a run are still checked and counted.
- done_o sets when source is in DONE and frame_cnt_o >= NUM_FRAMES.
- Timeout:
  - Counter increments in STREAM when neither interface transfers; it clears on any transfer.
  - When it reaches TIMEOUT_CYCLE, timeout_o sets (sticky until next start) and the source drops valid (abort is permitted only here).
- Asynchronous reset mid-frame: immediate return to reset values; no partial-frame state survives.

Decomposition:
- Package axis_image_vip_pkg: pattern_e enum (PAT_RAMP, PAT_CONST, PAT_PRBS, PAT_CHECK), src_state_e (IDLE, STREAM, DONE), LFSR polynomial and seed constants, function lfsr_next().
- Sub-module axis_image_frame_checker: sink counters, framing checks, checksum, error and frame counters.
- The top holds the source FSM, pattern generation, throttle and timeout.

Test Plan:
1. IMG_W=4, IMG_H=2, NUM_FRAMES=1, ramp, m looped to s, THROTTLE=0 -> data 0..7 on consecutive cycles, last on beats 3 and 7, user on beat 0; checksum_o=28, err_cnt_o=0, done_o=1.
2. Same geometry, THROTTLE=8 -> identical beat sequence; valid/data never change while valid && !ready; checksum_o=28.
3. Constant fill_i=24'h123456, NUM_FRAMES=2, loopback -> frame_cnt_o=2, checksum_o=8*0x123456=0x91A2B0, done_o=1.
4. Sink driven directly with last forced 0 on beat 3, then user=1 injected at sx=2 -> err_cnt_o increments by 1 then 1; resync yields next frame end at the expected count.
5. axis_m_ready_i held 0 after start, TIMEOUT_CYCLE=20 -> timeout_o=1 on the 20th idle cycle, valid drops, done_o=0.
6. rstn_i asserted mid-frame (beat 5), then released and start_i pulsed -> all outputs 0 during reset; new run restarts at data 0 with user=1.

Source files
------------

// File: rtl/axis_image_vip_pkg.sv
// Shared types and constants for the AXI4-Stream image pattern VIP.
// The same 32-bit Galois LFSR drives throttling and PRBS pixel data.
package axis_image_vip_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_PRBS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } src_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] SRC_SEED  = 32'hACE1_0001;
  localparam logic [31:0] SNK_SEED  = 32'h1357_9BDF;
  localparam logic [31:0] PRBS_SEED = 32'hACE1_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // Subtraction borrow avoids a constant compare when the threshold is zero.
  function automatic logic throttle_ok(input logic [3:0] lfsr_lo, input logic [3:0] thr);
    logic [4:0] diff;
    diff = {1'b0, lfsr_lo} - {1'b0, thr};
    return ~diff[4];
  endfunction

endpackage

// File: rtl/axis_image_frame_checker.sv
// Sink-side framing checker: tracks line/pixel position, counts SOF/EOL
// mismatches, and latches a per-frame checksum of the received pixels.
module axis_image_frame_checker
  import axis_image_vip_pkg::*;
#(
  parameter int DW    = 24,
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clear_i,
  input  logic          xfer_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          user_i,
  output logic [15:0]   err_cnt_o,
  output logic [15:0]   frame_cnt_o,
  output logic [31:0]   checksum_o
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

  logic [XW-1:0] sx_q, sx_d;
  logic [YW-1:0] sy_q, sy_d;
  logic [31:0]   acc_q, acc_d;
  logic [15:0]   err_q, err_d;
  logic [15:0]   frame_q, frame_d;
  logic [31:0]   sum_q, sum_d;

  logic          exp_last, exp_user;
  logic [16:0]   err_sum;
  logic [31:0]   data_ext;

  assign exp_last = (sx_q == XMAX);
  assign exp_user = (sx_q == '0) && (sy_q == '0);
  assign err_sum  = {1'b0, err_q} + 17'(last_i != exp_last) + 17'(user_i != exp_user);
  assign data_ext = 32'(data_i);

  // A stray SOF is treated as the first pixel of a fresh frame, so the
  // checksum and position restart from that beat.
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    acc_d   = acc_q;
    err_d   = err_q;
    frame_d = frame_q;
    sum_d   = sum_q;
    if (clear_i) begin
      sx_d    = '0;
      sy_d    = '0;
      acc_d   = '0;
      err_d   = '0;
      frame_d = '0;
      sum_d   = '0;
    end else if (xfer_i) begin
      err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (user_i && !exp_user) begin
        sx_d  = XW'(1);
        sy_d  = '0;
        acc_d = data_ext;
      end else if (exp_last && (sy_q == YMAX)) begin
        sum_d   = acc_q + data_ext;
        frame_d = frame_q + 16'd1;
        acc_d   = '0;
        sx_d    = '0;
        sy_d    = '0;
      end else begin
        acc_d = acc_q + data_ext;
        if (exp_last) begin
          sx_d = '0;
          sy_d = sy_q + YW'(1);
        end else begin
          sx_d = sx_q + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sx_q    <= '0;
      sy_q    <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      frame_q <= '0;
      sum_q   <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      frame_q <= frame_d;
      sum_q   <= sum_d;
    end
  end

  assign err_cnt_o   = err_q;
  assign frame_cnt_o = frame_q;
  assign checksum_o  = sum_q;

endmodule

// File: rtl/axis_image_pattern_vip.sv
// AXI4-Stream image VIP: pattern source with SOF/EOL sideband, throttled
// sink with framing checker, and a shared stall timeout.
module axis_image_pattern_vip
  import axis_image_vip_pkg::*;
#(
  parameter int PIX_BYTES     = 3,
  parameter int IMG_W         = 64,
  parameter int IMG_H         = 48,
  parameter int NUM_FRAMES    = 2,
  parameter int THROTTLE      = 0,
  parameter int TIMEOUT_CYCLE = 1000
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic [1:0]             pattern_sel_i,
  input  logic [PIX_BYTES*8-1:0] fill_i,
  output logic [PIX_BYTES*8-1:0] axis_m_data_o,
  output logic                   axis_m_valid_o,
  input  logic                   axis_m_ready_i,
  output logic                   axis_m_last_o,
  output logic                   axis_m_user_o,
  input  logic [PIX_BYTES*8-1:0] axis_s_data_i,
  input  logic                   axis_s_valid_i,
  output logic                   axis_s_ready_o,
  input  logic                   axis_s_last_i,
  input  logic                   axis_s_user_i,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [15:0]            err_cnt_o,
  output logic [15:0]            frame_cnt_o,
  output logic [31:0]            checksum_o
);

  localparam int DW = PIX_BYTES * 8;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [XW-1:0] XMAX      = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX      = YW'(IMG_H - 1);
  localparam logic [FW-1:0] FMAX      = FW'(NUM_FRAMES - 1);
  localparam logic [3:0]    THR       = 4'(THROTTLE);
  localparam logic [31:0]   TMO_LIMIT = 32'(TIMEOUT_CYCLE);

  src_state_e    state_q, state_d;
  pattern_e      pat_q, pat_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] f_q, f_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [31:0]   prbs_q, prbs_d;
  logic [31:0]   tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;
  logic [31:0]   src_lfsr_q, snk_lfsr_q;

  logic          m_xfer, s_xfer, idle, launch, last_beat, src_go;
  logic [31:0]   ramp;
  logic [DW-1:0] pix;

  assign src_go    = throttle_ok(src_lfsr_q[3:0], THR);
  assign m_xfer    = valid_q && axis_m_ready_i;
  assign s_xfer    = axis_s_valid_i && axis_s_ready_o;
  assign idle      = !m_xfer && !s_xfer;
  assign launch    = start_i && (state_q != STREAM);
  assign last_beat = (x_q == XMAX) && (y_q == YMAX) && (f_q == FMAX);
  assign ramp      = 32'(y_q) * 32'(IMG_W) + 32'(x_q);

  always_comb begin
    pix = '0;
    unique case (pat_q)
      PAT_RAMP:  pix = DW'(ramp);
      PAT_CONST: pix = fill_q;
      PAT_PRBS:  pix = DW'(prbs_q);
      PAT_CHECK: pix = (x_q[0] ^ y_q[0]) ? '1 : '0;
    endcase
  end

  // Sideband and data are qualified by valid so the port idles at zero.
  assign axis_m_valid_o = valid_q;
  assign axis_m_data_o  = valid_q ? pix : '0;
  assign axis_m_last_o  = valid_q && (x_q == XMAX);
  assign axis_m_user_o  = valid_q && (x_q == '0) && (y_q == '0);
  assign axis_s_ready_o = rstn_i && throttle_ok(snk_lfsr_q[3:0], THR);

  // Valid only rises on throttle-permitted cycles and is never withdrawn
  // before a handshake except by the stall timeout.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    x_d       = x_q;
    y_d       = y_q;
    f_d       = f_q;
    valid_d   = valid_q;
    fill_d    = fill_q;
    prbs_d    = prbs_q;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE: ;
      STREAM: begin
        if (m_xfer) begin
          prbs_d = lfsr_next(prbs_q);
          if (x_q == XMAX) begin
            x_d = '0;
            if (y_q == YMAX) begin
              y_d = '0;
              f_d = f_q + FW'(1);
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
        tmo_d = idle ? (tmo_q + 32'd1) : '0;
        if (m_xfer && last_beat) begin
          state_d = DONE;
          valid_d = 1'b0;
        end else if (idle && ((tmo_q + 32'd1) == TMO_LIMIT)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
          valid_d   = 1'b0;
        end else if (!valid_q || m_xfer) begin
          valid_d = src_go;
        end
      end
      DONE: begin
        if (frame_cnt_o >= 16'(NUM_FRAMES)) done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d   = STREAM;
      pat_d     = pattern_e'(pattern_sel_i);
      fill_d    = fill_i;
      prbs_d    = PRBS_SEED;
      x_d       = '0;
      y_d       = '0;
      f_d       = '0;
      valid_d   = 1'b0;
      tmo_d     = '0;
      timeout_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      pat_q      <= PAT_RAMP;
      x_q        <= '0;
      y_q        <= '0;
      f_q        <= '0;
      valid_q    <= 1'b0;
      fill_q     <= '0;
      prbs_q     <= PRBS_SEED;
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      src_lfsr_q <= SRC_SEED;
      snk_lfsr_q <= SNK_SEED;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      x_q        <= x_d;
      y_q        <= y_d;
      f_q        <= f_d;
      valid_q    <= valid_d;
      fill_q     <= fill_d;
      prbs_q     <= prbs_d;
      tmo_q      <= tmo_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      src_lfsr_q <= lfsr_next(src_lfsr_q);
      snk_lfsr_q <= lfsr_next(snk_lfsr_q);
    end
  end

  assign done_o    = done_q;
  assign timeout_o = timeout_q;

  axis_image_frame_checker #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_checker (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clear_i     (launch),
    .xfer_i      (s_xfer),
    .data_i      (axis_s_data_i),
    .last_i      (axis_s_last_i),
    .user_i      (axis_s_user_i),
    .err_cnt_o   (err_cnt_o),
    .frame_cnt_o (frame_cnt_o),
    .checksum_o  (checksum_o)
  );

endmodule

// File: tb/tb_axis_image_pattern_vip.sv
// Self-checking bench for axis_image_pattern_vip: a reference model fills a
// beat queue per run and a monitor pops/compares on every source handshake.
module tb_axis_image_pattern_vip;

  localparam int PIX_BYTES = 3;
  localparam int DW        = PIX_BYTES * 8;
  localparam int W         = 4;
  localparam int H         = 2;
  localparam int NF        = 2;
  localparam int THR       = 4;
  localparam int TMO       = 20;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    patSel;
  logic [DW-1:0] fill;
  logic [DW-1:0] mData, sData, dData;
  logic          mValid, mReady, mLast, mUser;
  logic          sValid, sReady, sLast, sUser;
  logic          dValid, dLast, dUser;
  logic          direct, gate;
  logic          done, timeout;
  logic [15:0]   errCnt, frameCnt;
  logic [31:0]   checksum;

  beat_t expQ[$];
  int    tests = 0;
  int    fails = 0;
  int    beatCount = 0;

  // In loopback the bench gate models a downstream that can stall both sides.
  assign mReady = direct ? gate   : (gate & sReady);
  assign sValid = direct ? dValid : (mValid & gate);
  assign sData  = direct ? dData  : mData;
  assign sLast  = direct ? dLast  : mLast;
  assign sUser  = direct ? dUser  : mUser;

  always #5 clock = ~clock;

  axis_image_pattern_vip #(
    .PIX_BYTES     (PIX_BYTES),
    .IMG_W         (W),
    .IMG_H         (H),
    .NUM_FRAMES    (NF),
    .THROTTLE      (THR),
    .TIMEOUT_CYCLE (TMO)
  ) dut (
    .clk_i          (clock),
    .rstn_i         (!reset),
    .start_i        (start),
    .pattern_sel_i  (patSel),
    .fill_i         (fill),
    .axis_m_data_o  (mData),
    .axis_m_valid_o (mValid),
    .axis_m_ready_i (mReady),
    .axis_m_last_o  (mLast),
    .axis_m_user_o  (mUser),
    .axis_s_data_i  (sData),
    .axis_s_valid_i (sValid),
    .axis_s_ready_o (sReady),
    .axis_s_last_i  (sLast),
    .axis_s_user_i  (sUser),
    .done_o         (done),
    .timeout_o      (timeout),
    .err_cnt_o      (errCnt),
    .frame_cnt_o    (frameCnt),
    .checksum_o     (checksum)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Reference model: enumerates every pixel of every frame in raster order.
  task automatic modelRun(input logic [1:0] p, input logic [DW-1:0] fv, output logic [31:0] lastSum);
    logic [31:0] prbs;
    logic [31:0] frameSum;
    beat_t       b;
    prbs    = 32'hACE1_0001;
    lastSum = '0;
    for (int f = 0; f < NF; f++) begin
      frameSum = '0;
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          case (p)
            2'd0: b.data = DW'(y * W + x);
            2'd1: b.data = fv;
            2'd2: begin
              b.data = prbs[DW-1:0];
              prbs   = galois(prbs);
            end
            default: b.data = (((x ^ y) & 1) == 1) ? {DW{1'b1}} : '0;
          endcase
          b.last = (x == W - 1);
          b.user = (x == 0) && (y == 0);
          expQ.push_back(b);
          frameSum += 32'(b.data);
        end
      end
      lastSum = frameSum;
    end
  endtask

  task automatic pulseStart();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] p, input logic [DW-1:0] fv, output logic [31:0] s);
    @(posedge clock); #1;
    patSel = p;
    fill   = fv;
    modelRun(p, fv, s);
    pulseStart();
    patSel = ~p;
    fill   = ~fv;
  endtask

  task automatic runPattern(input logic [1:0] p, input logic [DW-1:0] fv, output logic [31:0] s);
    applyStimulus(p, fv, s);
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clock); #1;
    end
    checkOutput("run_done", 32'(done), 32'd1);
    checkOutput("run_frames", 32'(frameCnt), 32'(NF));
    checkOutput("run_checksum", checksum, s);
    checkOutput("run_errors", 32'(errCnt), 32'd0);
    checkOutput("run_timeout", 32'(timeout), 32'd0);
    checkOutput("run_queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic sendBeat(input logic [DW-1:0] d, input logic l, input logic u);
    bit ok;
    ok     = 1'b0;
    dData  = d;
    dLast  = l;
    dUser  = u;
    dValid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock);
      if (sReady) ok = 1'b1;
      @(posedge clock); #1;
    end
    dValid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL sink_ready_wait: got 0 expected 1");
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m_valid"}, 32'(mValid), 32'd0);
    checkOutput({tag, "_m_data"}, 32'(mData), 32'd0);
    checkOutput({tag, "_m_last"}, 32'(mLast), 32'd0);
    checkOutput({tag, "_m_user"}, 32'(mUser), 32'd0);
    checkOutput({tag, "_s_ready"}, 32'(sReady), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, "_err_cnt"}, 32'(errCnt), 32'd0);
    checkOutput({tag, "_frame_cnt"}, 32'(frameCnt), 32'd0);
    checkOutput({tag, "_checksum"}, checksum, 32'd0);
  endtask

  // Monitor: pops the scoreboard on each source handshake and checks that
  // a stalled beat is held unchanged until accepted.
  initial begin : monitor
    beat_t e;
    logic  held;
    logic [DW-1:0] hd;
    logic  hl, hu;
    held = 1'b0;
    hd   = '0;
    hl   = 1'b0;
    hu   = 1'b0;
    forever begin
      @(negedge clock);
      if (held && !reset && !timeout) begin
        checkOutput("stall_valid_held", 32'(mValid), 32'd1);
        checkOutput("stall_beat_held", 32'({mData, mLast, mUser}), 32'({hd, hl, hu}));
      end
      held = 1'b0;
      if (!reset && mValid && mReady) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_beat: got data %0h expected no beat", mData);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_data", 32'(mData), 32'(e.data));
          checkOutput("beat_last", 32'(mLast), 32'(e.last));
          checkOutput("beat_user", 32'(mUser), 32'(e.user));
        end
        beatCount++;
      end else if (!reset && mValid) begin
        held = 1'b1;
        hd   = mData;
        hl   = mLast;
        hu   = mUser;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] s, sum;
    logic [13:0] lastTab, userTab;
    logic [DW-1:0] d;
    int base;
    reset  = 1'b1;
    start  = 1'b0;
    patSel = '0;
    fill   = '0;
    direct = 1'b1;
    gate   = 1'b1;
    dValid = 1'b0;
    dData  = '0;
    dLast  = 1'b0;
    dUser  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset");
    @(posedge clock); #2;
    reset = 1'b0;

    // Direct sink drive: missing EOL on beat 3, stray SOF on beat 6.
    lastTab = 14'h2200;
    userTab = 14'h0041;
    sum = '0;
    for (int i = 0; i < 14; i++) begin
      d = DW'($urandom);
      sendBeat(d, lastTab[i], userTab[i]);
      if (i >= 6) sum += 32'(d);
      if (i == 2) checkOutput("sink_err_clean", 32'(errCnt), 32'd0);
      if (i == 3) checkOutput("sink_err_missing_eol", 32'(errCnt), 32'd1);
      if (i == 5) checkOutput("sink_err_hold", 32'(errCnt), 32'd1);
      if (i == 6) checkOutput("sink_err_stray_sof", 32'(errCnt), 32'd2);
      if (i == 12) checkOutput("sink_frame_not_yet", 32'(frameCnt), 32'd0);
    end
    checkOutput("sink_frame_after_resync", 32'(frameCnt), 32'd1);
    checkOutput("sink_checksum_after_resync", checksum, sum);
    checkOutput("sink_err_total", 32'(errCnt), 32'd2);

    direct = 1'b0;
    runPattern(2'd0, DW'($urandom), s);
    checkOutput("ramp_checksum_28", checksum, 32'd28);
    runPattern(2'd1, 24'h123456, s);
    checkOutput("const_checksum", checksum, 32'h0091_A2B0);
    runPattern(2'd2, DW'($urandom), s);
    runPattern(2'd3, DW'($urandom), s);
    for (int r = 0; r < 3; r++) begin
      runPattern(2'($urandom_range(3)), DW'($urandom), s);
    end

    // Stall timeout with the downstream never ready.
    gate = 1'b0;
    pulseStart();
    repeat (19) @(posedge clock);
    #1;
    checkOutput("timeout_not_early", 32'(timeout), 32'd0);
    checkOutput("timeout_valid_held", 32'(mValid), 32'd1);
    @(posedge clock); #1;
    checkOutput("timeout_set", 32'(timeout), 32'd1);
    checkOutput("timeout_valid_dropped", 32'(mValid), 32'd0);
    checkOutput("timeout_no_done", 32'(done), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("timeout_sticky", 32'(timeout), 32'd1);
    checkOutput("timeout_still_no_done", 32'(done), 32'd0);
    gate = 1'b1;

    // Asynchronous reset after five beats of a run, then a clean restart.
    base = beatCount;
    applyStimulus(2'd0, '0, s);
    for (int c = 0; c < 500 && beatCount < base + 5; c++) begin
      @(posedge clock); #2;
    end
    checkOutput("beats_before_reset", 32'(beatCount - base), 32'd5);
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    expQ.delete();
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    runPattern(2'd0, '0, s);
    checkOutput("restart_checksum_28", checksum, 32'd28);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
